// File: rtl/led_fade_driver.sv
// rtl/led_fade_driver.sv - PWM crossfade LED output stage with valid/ready pattern input
module led_fade_driver #(
  parameter int unsigned PWM_BITS   = 8,
  parameter logic [31:0] STEP_CYC   = 32'd195_312,
  parameter bit          ACTIVE_LOW = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] pat_in,
  input  logic        pat_vld,
  output logic        pat_rdy,
  input  logic        fade_skip,
  output logic        fade_busy,
  output logic [15:0] cur_pat,
  output logic [15:0] led
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_FADE = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [PWM_BITS-1:0] DUTY_MAX = '1;
  localparam logic [PWM_BITS-1:0] PWM_ONE  = PWM_BITS'(1);
  localparam logic [31:0]         STEP_LAST = STEP_CYC - 32'd1;
  localparam logic [15:0]         LED_OFF  = ACTIVE_LOW ? 16'hFFFF : 16'h0000;

  logic [1:0]          r_state;
  logic [15:0]         r_cur_pat;
  logic [15:0]         r_nxt_pat;
  logic [PWM_BITS-1:0] r_duty;
  logic [PWM_BITS-1:0] r_pwm_cnt;
  logic [31:0]         r_step_cnt;
  logic [15:0]         r_led;

  logic [1:0]  w_state_nxt;
  logic        w_rdy;
  logic        w_busy;
  logic        w_xfer;
  logic        w_new_pat;
  logic        w_step_end;
  logic [15:0] w_composite;

  assign pat_rdy    = w_rdy & rst_n;
  assign w_xfer     = pat_vld & pat_rdy;
  assign w_new_pat  = w_xfer && (pat_in != r_cur_pat);
  assign w_step_end = (r_step_cnt == STEP_LAST);
  assign fade_busy  = w_busy;
  assign cur_pat    = r_cur_pat;
  assign led        = r_led;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Skip outranks the step logic, so a skip on the terminal step still lands in DONE.
  always_comb begin
    w_state_nxt = S_IDLE;
    case (r_state)
      S_IDLE: w_state_nxt = w_new_pat ? S_FADE : S_IDLE;
      S_FADE: begin
        if (fade_skip || (w_step_end && (r_duty == DUTY_MAX))) begin
          w_state_nxt = S_DONE;
        end else begin
          w_state_nxt = S_FADE;
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_rdy       = 1'b0;
    w_busy      = 1'b0;
    w_composite = r_cur_pat;
    case (r_state)
      S_IDLE: w_rdy = 1'b1;
      S_FADE: begin
        w_busy      = 1'b1;
        w_composite = (r_pwm_cnt < r_duty) ? r_nxt_pat : r_cur_pat;
      end
      S_DONE: begin
        w_busy      = 1'b1;
        w_composite = r_nxt_pat;
      end
      default: w_composite = r_cur_pat;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cur_pat  <= '0;
      r_nxt_pat  <= '0;
      r_duty     <= '0;
      r_step_cnt <= '0;
      r_pwm_cnt  <= '0;
      r_led      <= LED_OFF;
    end else begin
      r_pwm_cnt <= r_pwm_cnt + PWM_ONE;
      r_led     <= ACTIVE_LOW ? ~w_composite : w_composite;
      case (r_state)
        S_IDLE: begin
          if (w_new_pat) begin
            r_nxt_pat  <= pat_in;
            r_duty     <= '0;
            r_step_cnt <= '0;
          end
        end
        S_FADE: begin
          if (!fade_skip) begin
            if (w_step_end) begin
              r_step_cnt <= '0;
              if (r_duty != DUTY_MAX) begin
                r_duty <= r_duty + PWM_ONE;
              end
            end else begin
              r_step_cnt <= r_step_cnt + 32'd1;
            end
          end
        end
        S_DONE: begin
          r_cur_pat <= r_nxt_pat;
          r_duty    <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_led_fade_driver.sv
// tb/tb_led_fade_driver.sv - table and scoreboard checks for led_fade_driver
module tb_led_fade_driver;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        pat_vld;
  logic        fade_skip;
  logic [15:0] pat_in;
  logic        pat_rdy, fade_busy, pat_rdy_h, fade_busy_h;
  logic [15:0] cur_pat, led, cur_pat_h, led_h;

  int          checks = 0;
  int          errors = 0;
  logic [15:0] exp_q[$];
  logic [15:0] m_cur;
  logic        prev_busy = 1'b0;

  always #5 clk = ~clk;

  led_fade_driver #(.PWM_BITS(2), .STEP_CYC(32'd4), .ACTIVE_LOW(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .pat_in(pat_in), .pat_vld(pat_vld), .pat_rdy(pat_rdy),
    .fade_skip(fade_skip), .fade_busy(fade_busy), .cur_pat(cur_pat), .led(led)
  );

  led_fade_driver #(.PWM_BITS(2), .STEP_CYC(32'd4), .ACTIVE_LOW(1'b0)) dut_h (
    .clk(clk), .rst_n(rst_n), .pat_in(pat_in), .pat_vld(pat_vld), .pat_rdy(pat_rdy_h),
    .fade_skip(fade_skip), .fade_busy(fade_busy_h), .cur_pat(cur_pat_h), .led(led_h)
  );

  typedef struct {
    logic [15:0] pat;
    int          skip_at;
    int          busy;
    logic [15:0] cur;
    logic [15:0] led;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: each accepted fade's target must be on cur_pat when busy drops.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_busy <= 1'b0;
    end else begin
      if (prev_busy && !fade_busy) begin
        if (exp_q.size() == 0) chk("sb_unexpected_done", 32'd1, 32'd0);
        else chk("sb_cur_pat", 32'(cur_pat), 32'(exp_q.pop_front()));
      end
      prev_busy <= fade_busy;
    end
  end

  task automatic do_vec(input vec_t v);
    int          n;
    int          viol;
    int          act;
    int          w;
    int          cnt[4][16];
    logic [15:0] old_p;
    logic [15:0] diff;
    for (int a = 0; a < 4; a++)
      for (int b = 0; b < 16; b++) cnt[a][b] = 0;
    old_p   = m_cur;
    diff    = old_p ^ v.pat;
    viol    = 0;
    pat_in  = v.pat;
    pat_vld = 1'b1;
    for (int t = 0; t < 40 && !pat_rdy; t++) tick();
    chk("rdy", 32'(pat_rdy), 32'd1);
    if (diff != '0) exp_q.push_back(v.pat);
    tick();
    pat_vld = 1'b0;
    n = 0;
    while (fade_busy === 1'b1 && n < 100) begin
      for (int i = 0; i < 16; i++) begin
        if (!diff[i]) begin
          if (~led[i] != old_p[i]) viol++;
        end else if (n >= 1 && n <= 16) begin
          w = (n - 1) / 4;
          if (~led[i] == v.pat[i]) cnt[w][i]++;
        end
      end
      fade_skip = (n == v.skip_at);
      n++;
      tick();
    end
    fade_skip = 1'b0;
    chk("busy_len", 32'(n), 32'(v.busy));
    chk("cur_pat", 32'(cur_pat), 32'(v.cur));
    chk("led", 32'(led), 32'(v.led));
    chk("led_active_high", 32'(led_h), 32'(v.cur));
    chk("steady_bits", 32'(viol), 32'd0);
    if (v.skip_at < 0 && diff != '0) begin
      for (int k = 0; k < 4; k++) begin
        act = k;
        for (int i = 0; i < 16; i++)
          if (diff[i] && cnt[k][i] != k) act = cnt[k][i];
        chk("fade_window_lit", 32'(act), 32'(k));
      end
    end
    m_cur = v.pat;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    vecs[0] = '{16'h55AA, -1, 17, 16'h55AA, 16'hAA55};
    vecs[1] = '{16'h55AA, -1,  0, 16'h55AA, 16'hAA55};
    vecs[2] = '{16'h789A,  5,  7, 16'h789A, 16'h8765};
    vecs[3] = '{16'h0000,  0,  2, 16'h0000, 16'hFFFF};
    vecs[4] = '{16'hFFFF, -1, 17, 16'hFFFF, 16'h0000};
    vecs[5] = '{16'h8001,  2,  4, 16'h8001, 16'h7FFE};

    rst_n = 1'b0; pat_vld = 1'b1; pat_in = 16'h55AA; fade_skip = 1'b1; m_cur = 16'h0000;
    repeat (3) tick();
    chk("rst_led", 32'(led), 32'hFFFF);
    chk("rst_led_active_high", 32'(led_h), 32'h0000);
    chk("rst_cur_pat", 32'(cur_pat), 32'h0000);
    chk("rst_busy", 32'(fade_busy), 32'd0);
    chk("rst_rdy_low", 32'(pat_rdy), 32'd0);
    pat_vld = 1'b0; fade_skip = 1'b0; rst_n = 1'b1;
    #1;
    chk("rdy_after_release", 32'(pat_rdy), 32'd1);
    tick();
    chk("no_xfer_in_reset", 32'(cur_pat), 32'h0000);

    for (int k = 0; k < 5; k++) begin
      if (k == 1) fade_skip = 1'b1;
      do_vec(vecs[k]);
      fade_skip = 1'b0;
    end

    // Back-to-back: second pattern held valid through a whole fade.
    pat_in = 16'h55AA; pat_vld = 1'b1;
    chk("b2b_rdy", 32'(pat_rdy), 32'd1);
    exp_q.push_back(16'h55AA);
    tick();
    pat_in = 16'h789A;
    n = 0;
    while (pat_rdy !== 1'b1 && n < 100) begin
      n++;
      tick();
    end
    chk("b2b_stall", 32'(n), 32'd17);
    chk("b2b_first_cur", 32'(cur_pat), 32'h55AA);
    exp_q.push_back(16'h789A);
    tick();
    pat_vld = 1'b0;
    chk("b2b_busy", 32'(fade_busy), 32'd1);
    chk("b2b_from_cur", 32'(cur_pat), 32'h55AA);
    chk("b2b_led_start", 32'(led), 32'hAA55);
    fade_skip = 1'b1;
    tick();
    fade_skip = 1'b0;
    chk("b2b_done_busy", 32'(fade_busy), 32'd1);
    tick();
    chk("b2b_idle", 32'(fade_busy), 32'd0);
    chk("b2b_cur", 32'(cur_pat), 32'h789A);
    chk("b2b_led", 32'(led), 32'h8765);
    m_cur = 16'h789A;

    // Reset in the middle of a fade.
    pat_in = 16'h0F0F; pat_vld = 1'b1;
    exp_q.push_back(16'h0F0F);
    tick();
    pat_vld = 1'b0;
    repeat (9) tick();
    chk("mid_busy", 32'(fade_busy), 32'd1);
    rst_n = 1'b0;
    exp_q.delete();
    tick();
    chk("mid_rst_busy", 32'(fade_busy), 32'd0);
    chk("mid_rst_cur", 32'(cur_pat), 32'h0000);
    chk("mid_rst_led", 32'(led), 32'hFFFF);
    chk("mid_rst_led_active_high", 32'(led_h), 32'h0000);
    rst_n = 1'b1;
    m_cur = 16'h0000;
    #1;
    chk("mid_rst_rdy", 32'(pat_rdy), 32'd1);
    tick();

    do_vec(vecs[5]);
    repeat (2) tick();
    chk("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
